// File: rtl/histogram_pkg.sv
// Shared types and sizing helpers for the dual-bank pixel histogram.
package histogram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } hist_state_e;

  // Only mono (1) and Bayer (4) channel layouts are supported.
  function automatic bit nch_legal(input int unsigned nch);
    return (nch == 1) || (nch == 4);
  endfunction

  // Channel index bits in a bank-local address.
  function automatic int unsigned ch_bits(input int unsigned nch);
    return (nch == 4) ? 2 : 0;
  endfunction

  // Bank-local address width: {channel, bin}.
  function automatic int unsigned loc_addr_w(input int unsigned nch, input int unsigned bin_w);
    return ch_bits(nch) + bin_w;
  endfunction

  // Full RAM address width: {bank, channel, bin}.
  function automatic int unsigned ram_addr_w(input int unsigned nch, input int unsigned bin_w);
    return loc_addr_w(nch, bin_w) + 1;
  endfunction

endpackage

// File: rtl/hist_bank_ram.sv
// Two-bank counter storage: one write port, an accumulate read port and a
// readout read port, both reads registered (1-cycle latency, old data on
// a same-cycle write).
module hist_bank_ram #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 20
) (
  input  logic          pclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Single write port shared by bank clearing and counter writeback.
  always_ff @(posedge pclk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered reads for the increment pipeline and the host readout.
  always_ff @(posedge pclk) begin
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/histogram_par.sv
// Per-channel pixel histogram over a programmable window, double-banked so
// one completed frame can be read while the next accumulates.
module histogram_par
  import histogram_pkg::*;
#(
  parameter int unsigned PIX_W = 12,
  parameter int unsigned BIN_W = 8,
  parameter int unsigned CNT_W = 20,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DIM_W = 14
) (
  input  logic                                pclk,
  input  logic                                rst_n,
  input  logic                                frame_run,
  input  logic                                line_run,
  input  logic                                pix_vld,
  input  logic [PIX_W-1:0]                    pix,
  input  logic [1:0]                          bayer_phase,
  input  logic [DIM_W-1:0]                    win_left,
  input  logic [DIM_W-1:0]                    win_top,
  input  logic [DIM_W-1:0]                    win_width_m1,
  input  logic [DIM_W-1:0]                    win_height_m1,
  input  logic [3:0]                          cfg_shift,
  input  logic                                cfg_sat,
  input  logic                                rd_en,
  input  logic [loc_addr_w(NCH, BIN_W)-1:0]   rd_addr,
  output logic [CNT_W-1:0]                    rd_data,
  output logic                                rd_vld,
  output logic                                hist_ready,
  output logic                                clr_late
);

  localparam int unsigned LA_W = loc_addr_w(NCH, BIN_W);
  localparam int unsigned RA_W = ram_addr_w(NCH, BIN_W);

  if (!nch_legal(NCH)) begin : g_bad_nch
    $error("histogram_par: NCH must be 1 or 4");
  end

  hist_state_e      state_q;
  logic             bank_sel_q;
  logic [LA_W-1:0]  clr_cnt_q;

  logic             frame_run_q;
  logic             line_run_q;
  logic [DIM_W-1:0] col_q;
  logic [DIM_W-1:0] row_q;

  logic [3:0]       shift_q;
  logic             sat_q;
  logic [1:0]       phase_q;
  logic [DIM_W-1:0] win_left_q;
  logic [DIM_W-1:0] win_top_q;
  logic [DIM_W-1:0] win_width_m1_q;
  logic [DIM_W-1:0] win_height_m1_q;

  logic             s1_vld, s2_vld, s3_vld;
  logic [RA_W-1:0]  s1_addr, s2_addr, s3_addr;
  logic [CNT_W-1:0] s2_data, s3_data;
  logic             rd_en_q;

  logic             frame_rise, line_rise, line_fall;
  logic [DIM_W-1:0] col_cur, row_cur;
  logic [DIM_W:0]   col_x, row_x, left_x, top_x, right_x, bot_x;
  logic             in_win, pix_hit, acc_c, late_c;
  logic [PIX_W-1:0] pix_sh;
  logic [BIN_W-1:0] bin_c;
  logic [1:0]       ch_c;
  logic [LA_W-1:0]  la_c;

  logic             ram_we;
  logic [RA_W-1:0]  ram_waddr, ram_raddr_a, ram_raddr_b;
  logic [CNT_W-1:0] ram_wdata, ram_rdata_a, ram_rdata_b;
  logic [CNT_W-1:0] cnt_src, cnt_inc;

  // Edge detection, window position of the current pixel and bin/channel.
  always_comb begin
    frame_rise = frame_run & ~frame_run_q;
    line_rise  = line_run & ~line_run_q;
    line_fall  = ~line_run & line_run_q;
    col_cur    = line_rise ? '0 : col_q;
    row_cur    = frame_rise ? '0 : row_q;
    col_x      = {1'b0, col_cur};
    row_x      = {1'b0, row_cur};
    left_x     = {1'b0, win_left_q};
    top_x      = {1'b0, win_top_q};
    right_x    = {1'b0, win_left_q} + {1'b0, win_width_m1_q};
    bot_x      = {1'b0, win_top_q} + {1'b0, win_height_m1_q};
    in_win     = (col_x >= left_x) && (col_x <= right_x) &&
                 (row_x >= top_x) && (row_x <= bot_x);
    pix_hit    = line_run & pix_vld & in_win;
    acc_c      = (state_q == ST_ACCUM) & pix_hit;
    late_c     = (state_q == ST_CLEAR) & pix_hit;
    pix_sh     = pix >> shift_q;
    bin_c      = BIN_W'(pix_sh);
    ch_c       = (NCH == 4) ? {row_cur[0] ^ phase_q[1], col_cur[0] ^ phase_q[0]} : 2'b00;
    la_c       = (LA_W'(ch_c) << BIN_W) | LA_W'(bin_c);
  end

  // Frame state machine; banks swap only when a new frame follows a completed one.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bank_sel_q <= 1'b0;
      hist_ready <= 1'b0;
      clr_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_rise) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
          end
        end
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + LA_W'(1);
          if (&clr_cnt_q) state_q <= ST_ACCUM;
        end
        ST_ACCUM: begin
          // Leave only once every accepted pixel has been written back.
          if (!frame_run && !acc_c && !s1_vld && !s2_vld) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (frame_rise) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            bank_sel_q <= ~bank_sel_q;
            hist_ready <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Input edge history, frame configuration capture and column/row tracking.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      // Track frame_run through reset so a frame already running is not a new start.
      frame_run_q     <= frame_run;
      line_run_q      <= 1'b0;
      col_q           <= '0;
      row_q           <= '0;
      shift_q         <= '0;
      sat_q           <= 1'b0;
      phase_q         <= '0;
      win_left_q      <= '0;
      win_top_q       <= '0;
      win_width_m1_q  <= '0;
      win_height_m1_q <= '0;
    end else begin
      frame_run_q <= frame_run;
      line_run_q  <= line_run;
      col_q       <= pix_vld ? col_cur + DIM_W'(1) : col_cur;
      if (line_fall) row_q <= row_cur + DIM_W'(1);
      else           row_q <= row_cur;
      if (frame_rise) begin
        shift_q         <= cfg_shift;
        sat_q           <= cfg_sat;
        phase_q         <= bayer_phase;
        win_left_q      <= win_left;
        win_top_q       <= win_top;
        win_width_m1_q  <= win_width_m1;
        win_height_m1_q <= win_height_m1;
      end
    end
  end

  // Increment stage: newest in-flight value for the same address wins over RAM data.
  always_comb begin
    cnt_src = ram_rdata_a;
    if (s3_vld && (s3_addr == s1_addr)) cnt_src = s3_data;
    if (s2_vld && (s2_addr == s1_addr)) cnt_src = s2_data;
    cnt_inc = (sat_q && (&cnt_src)) ? cnt_src : cnt_src + CNT_W'(1);
  end

  // Read / increment / write pipeline; stage 3 remembers the last write for forwarding.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s3_vld  <= 1'b0;
      s1_addr <= '0;
      s2_addr <= '0;
      s3_addr <= '0;
      s2_data <= '0;
      s3_data <= '0;
    end else begin
      s1_vld  <= acc_c;
      s1_addr <= ram_raddr_a;
      s2_vld  <= s1_vld;
      s2_addr <= s1_addr;
      s2_data <= cnt_inc;
      s3_vld  <= s2_vld;
      s3_addr <= s2_addr;
      s3_data <= s2_data;
    end
  end

  // Sticky flag for in-window pixels that arrived while the bank was still clearing.
  always_ff @(posedge pclk) begin
    if (!rst_n)      clr_late <= 1'b0;
    else if (late_c) clr_late <= 1'b1;
  end

  // Host readout from the bank opposite the accumulate bank.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      rd_en_q <= 1'b0;
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_en_q <= rd_en;
      rd_vld  <= rd_en_q;
      if (rd_en_q) rd_data <= ram_rdata_b;
    end
  end

  // RAM port steering: clearing owns the write port for the whole CLEAR phase.
  always_comb begin
    ram_raddr_a = {bank_sel_q, la_c};
    ram_raddr_b = {~bank_sel_q, rd_addr};
    ram_we      = s2_vld;
    ram_waddr   = s2_addr;
    ram_wdata   = s2_data;
    if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = {bank_sel_q, clr_cnt_q};
      ram_wdata = '0;
    end
  end

  hist_bank_ram #(
    .AW (RA_W),
    .DW (CNT_W)
  ) u_ram (
    .pclk    (pclk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (ram_raddr_a),
    .rdata_a (ram_rdata_a),
    .raddr_b (ram_raddr_b),
    .rdata_b (ram_rdata_b)
  );

endmodule

// File: tb/tb_histogram_par.sv
// Directed bench: a Bayer instance, a mono instance and a 4-bit-counter mono
// instance share all stimulus; each readout is compared against hand-computed bins.
module tb_histogram_par;

  localparam int CLR_WAIT = 1030;

  logic        pclk;
  logic        rst_n;
  logic        frame_run, line_run, pix_vld;
  logic [11:0] pix;
  logic [1:0]  bayer_phase;
  logic [13:0] win_left, win_top, win_width_m1, win_height_m1;
  logic [3:0]  cfg_shift;
  logic        cfg_sat;
  logic        rd_en;
  logic [9:0]  rd_addr;

  logic [19:0] d_rd_data;
  logic        d_rd_vld, d_hist_ready, d_clr_late;
  logic [19:0] m_rd_data;
  logic        m_rd_vld, m_hist_ready, m_clr_late;
  logic [3:0]  s_rd_data;
  logic        s_rd_vld, s_hist_ready, s_clr_late;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ph;
    int addr;
    int e_d;
    int e_m;
    int e_s;
  } vec_t;

  vec_t tab[$];

  histogram_par u_dut (
    .pclk(pclk), .rst_n(rst_n), .frame_run(frame_run), .line_run(line_run),
    .pix_vld(pix_vld), .pix(pix), .bayer_phase(bayer_phase),
    .win_left(win_left), .win_top(win_top), .win_width_m1(win_width_m1),
    .win_height_m1(win_height_m1), .cfg_shift(cfg_shift), .cfg_sat(cfg_sat),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d_rd_data), .rd_vld(d_rd_vld),
    .hist_ready(d_hist_ready), .clr_late(d_clr_late)
  );

  histogram_par #(.NCH(1)) u_mono (
    .pclk(pclk), .rst_n(rst_n), .frame_run(frame_run), .line_run(line_run),
    .pix_vld(pix_vld), .pix(pix), .bayer_phase(bayer_phase),
    .win_left(win_left), .win_top(win_top), .win_width_m1(win_width_m1),
    .win_height_m1(win_height_m1), .cfg_shift(cfg_shift), .cfg_sat(cfg_sat),
    .rd_en(rd_en), .rd_addr(rd_addr[7:0]), .rd_data(m_rd_data), .rd_vld(m_rd_vld),
    .hist_ready(m_hist_ready), .clr_late(m_clr_late)
  );

  histogram_par #(.NCH(1), .CNT_W(4)) u_sat (
    .pclk(pclk), .rst_n(rst_n), .frame_run(frame_run), .line_run(line_run),
    .pix_vld(pix_vld), .pix(pix), .bayer_phase(bayer_phase),
    .win_left(win_left), .win_top(win_top), .win_width_m1(win_width_m1),
    .win_height_m1(win_height_m1), .cfg_shift(cfg_shift), .cfg_sat(cfg_sat),
    .rd_en(rd_en), .rd_addr(rd_addr[7:0]), .rd_data(s_rd_data), .rd_vld(s_rd_vld),
    .hist_ready(s_hist_ready), .clr_late(s_clr_late)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic set_cfg(input int l, input int t, input int w, input int h,
                         input int sh, input logic sat, input logic [1:0] bp);
    win_left      = 14'(l);
    win_top       = 14'(t);
    win_width_m1  = 14'(w);
    win_height_m1 = 14'(h);
    cfg_shift     = 4'(sh);
    cfg_sat       = sat;
    bayer_phase   = bp;
  endtask

  task automatic start_frame();
    frame_run = 1'b1;
    repeat (CLR_WAIT) tick();
  endtask

  task automatic end_frame();
    frame_run = 1'b0;
    repeat (5) tick();
  endtask

  task automatic send_line(input int n, input logic [11:0] p);
    line_run = 1'b1;
    pix_vld  = 1'b1;
    pix      = p;
    repeat (n) tick();
    pix_vld  = 1'b0;
    line_run = 1'b0;
    tick();
    tick();
  endtask

  // Issue one read and check all three instances, including the 2-cycle latency.
  task automatic rd_chk(input string nm, input int a, input int ed, input int em, input int es);
    rd_en   = 1'b1;
    rd_addr = 10'(a);
    tick();
    rd_en = 1'b0;
    chk({nm, "_vld_early"}, int'(d_rd_vld), 0);
    tick();
    chk({nm, "_vld"}, int'(d_rd_vld), 1);
    chk({nm, "_dut"}, int'(d_rd_data), ed);
    chk({nm, "_mono"}, int'(m_rd_data), em);
    chk({nm, "_sat"}, int'(s_rd_data), es);
  endtask

  task automatic check_phase(input int ph);
    foreach (tab[i]) begin
      if (tab[i].ph == ph)
        rd_chk($sformatf("p%0d_a%0d", ph, tab[i].addr), tab[i].addr,
               tab[i].e_d, tab[i].e_m, tab[i].e_s);
    end
  endtask

  task automatic chk_flags(input string nm, input int hr, input int cl);
    chk({nm, "_hr_dut"},  int'(d_hist_ready), hr);
    chk({nm, "_hr_mono"}, int'(m_hist_ready), hr);
    chk({nm, "_hr_sat"},  int'(s_hist_ready), hr);
    chk({nm, "_cl_dut"},  int'(d_clr_late), cl);
    chk({nm, "_cl_mono"}, int'(m_clr_late), cl);
    chk({nm, "_cl_sat"},  int'(s_clr_late), cl);
  endtask

  task automatic chk_rd_zero(input string nm);
    chk({nm, "_vld_dut"},  int'(d_rd_vld), 0);
    chk({nm, "_vld_mono"}, int'(m_rd_vld), 0);
    chk({nm, "_vld_sat"},  int'(s_rd_vld), 0);
    chk({nm, "_dat_dut"},  int'(d_rd_data), 0);
    chk({nm, "_dat_mono"}, int'(m_rd_data), 0);
    chk({nm, "_dat_sat"},  int'(s_rd_data), 0);
  endtask

  initial begin
    rst_n = 1'b0; frame_run = 1'b0; line_run = 1'b0; pix_vld = 1'b0; pix = '0;
    rd_en = 1'b0; rd_addr = '0;
    set_cfg(0, 0, 0, 0, 0, 1'b0, 2'b00);

    // {phase, addr, bayer, mono, 4-bit counter}
    // Phase 1: 8x4 window at (2,1), pix 0x100 >> 4 -> bin 16, saturating.
    tab.push_back('{1,  16,   8,   32, 15});
    tab.push_back('{1, 272,   8,   32, 15});
    tab.push_back('{1, 528,   8,   32, 15});
    tab.push_back('{1, 784,   8,   32, 15});
    tab.push_back('{1,  15,   0,    0,  0});
    tab.push_back('{1,  17,   0,    0,  0});
    tab.push_back('{1, 511,   0,    0,  0});
    // Phase 2: 1000 back-to-back bin-42 hits on row 0, 20 bin-7 hits on row 1, wrapping.
    tab.push_back('{2,  42, 500, 1000,  8});
    tab.push_back('{2, 298, 500, 1000,  8});
    tab.push_back('{2, 519,  10,   20,  4});
    tab.push_back('{2, 775,  10,   20,  4});
    tab.push_back('{2,   7,   0,   20,  4});
    // Phase 3: early pixels during CLEAR dropped, 20 bin-7 hits saturating.
    tab.push_back('{3, 519,  10,   20, 15});
    tab.push_back('{3, 775,  10,   20, 15});
    tab.push_back('{3,   5,   0,    0,  0});
    tab.push_back('{3, 261,   0,    0,  0});
    // Phase 4: only the post-reset frame's four bin-9 hits.
    tab.push_back('{4,   9,   2,    4,  4});
    tab.push_back('{4, 265,   2,    4,  4});

    repeat (3) tick();
    chk_flags("reset", 0, 0);
    chk_rd_zero("reset");
    rst_n = 1'b1;
    tick();

    // Frame 1 (first after reset): never sets hist_ready.
    set_cfg(2, 1, 7, 3, 4, 1'b1, 2'b00);
    start_frame();
    for (int r = 0; r < 6; r++) send_line(12, 12'h100);
    end_frame();
    chk_flags("f1_done", 0, 0);

    // Frame 2: swap exposes frame 1.
    set_cfg(0, 0, 999, 1, 4, 1'b0, 2'b00);
    start_frame();
    chk_flags("f2_run", 1, 0);
    check_phase(1);
    send_line(1004, 12'h2A0);
    send_line(20, 12'h070);
    send_line(3, 12'h070);
    end_frame();

    // Frame 3: a line starts 10 cycles into CLEAR.
    set_cfg(0, 0, 999, 99, 4, 1'b1, 2'b00);
    frame_run = 1'b1;
    repeat (10) tick();
    send_line(5, 12'h050);
    chk_flags("f3_late", 1, 1);
    repeat (CLR_WAIT - 17) tick();
    check_phase(2);
    send_line(20, 12'h070);
    end_frame();

    // Frame 4: a read in the swap cycle still sees the old readout bank (frame 2).
    set_cfg(0, 0, 999, 99, 4, 1'b0, 2'b00);
    frame_run = 1'b1;
    rd_en     = 1'b1;
    rd_addr   = 10'd42;
    tick();
    rd_en = 1'b0;
    tick();
    chk("swap_rd_dut",  int'(d_rd_data), 500);
    chk("swap_rd_mono", int'(m_rd_data), 1000);
    chk("swap_rd_sat",  int'(s_rd_data), 8);
    repeat (CLR_WAIT - 2) tick();
    check_phase(3);
    send_line(6, 12'h090);

    // Reset mid-ACCUM after a completed read: every output must return to zero.
    rd_en   = 1'b1;
    rd_addr = 10'd519;
    tick();
    rd_en = 1'b0;
    tick();
    chk("pre_rst_dut",  int'(d_rd_data), 10);
    chk("pre_rst_mono", int'(m_rd_data), 20);
    rst_n = 1'b0;
    tick();
    tick();
    chk_flags("mid_rst", 0, 0);
    chk_rd_zero("mid_rst");
    rst_n     = 1'b1;
    frame_run = 1'b0;
    repeat (3) tick();

    // Frame 5: restarts from CLEAR; first frame after reset again.
    start_frame();
    send_line(4, 12'h090);
    end_frame();
    chk_flags("f5_done", 0, 0);

    // Frame 6: swap exposes frame 5.
    frame_run = 1'b1;
    tick();
    chk_flags("f6_run", 1, 0);
    check_phase(4);
    frame_run = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/histogram_par.md
HISTOGRAM_PAR -- requirements
Module: histogram_par

Interface
REQ-001 SHALL have parameter PIX_W, default 12, input pixel width.
REQ-002 SHALL have parameter BIN_W, default 8, bin index width (2^BIN_W bins per channel).
REQ-003 SHALL have parameter CNT_W, default 20, bin counter width.
REQ-004 SHALL have parameter NCH, default 4, channel count: legal values 1 (mono) and 4 (Bayer).
REQ-005 SHALL have parameter DIM_W, default 14, window coordinate width.
REQ-006 SHALL be single clock domain, reset synchronous active-low.
REQ-007 SHALL have port pclk, in, 1, pixel clock; all logic on posedge.
REQ-008 SHALL have port rst_n, in, 1, synchronous active-low reset.
REQ-009 SHALL have ports frame_run, line_run, pix_vld, each in, 1: frame active, line active, pixel valid.
REQ-010 SHALL have port pix, in, PIX_W: pixel value, qualified by pix_vld.
REQ-011 SHALL have port bayer_phase, in, 2: colour of first pixel; ignored when NCH=1.
REQ-012 SHALL have ports win_left, win_top, win_width_m1, win_height_m1, each in, DIM_W: window geometry; window size = value+1.
REQ-013 SHALL have port cfg_shift, in, 4: bin = pix >> cfg_shift, truncated to BIN_W.
REQ-014 SHALL have port cfg_sat, in, 1: 1 saturates counters, 0 wraps them.
REQ-015 SHALL have ports rd_en, in, 1, and rd_addr, in, log2(NCH)+BIN_W: read request {channel,bin}.
REQ-016 SHALL have ports rd_data, out, CNT_W, and rd_vld, out, 1: read result.
REQ-017 SHALL have ports hist_ready, out, 1, readout bank holds a completed frame; clr_late, out, 1, sticky error.

Function
REQ-018 SHALL keep two banks of NCH*2^BIN_W counters; the accumulate bank and readout bank are always opposite.
REQ-019 SHALL latch cfg ports and bayer_phase on the frame_run rising edge; they SHALL be stable for that frame.
REQ-020 SHALL run state machine IDLE->CLEAR on frame_run rise; CLEAR->ACCUM after NCH*2^BIN_W cycles; ACCUM->DONE on frame_run fall; DONE->CLEAR on the next frame_run rise.
REQ-021 SHALL swap banks on the DONE->CLEAR transition only, then set hist_ready=1; the first frame after reset SHALL NOT set hist_ready.
REQ-022 SHALL write zero to one accumulate-bank address per CLEAR cycle.
REQ-023 SHALL drop in-window pixels arriving during CLEAR, leave them uncounted, and set clr_late=1 until reset.
REQ-024 SHALL advance the column counter per pix_vld and reset it on line_run rise; the row counter SHALL advance on line_run fall.
REQ-025 SHALL count a pixel iff state=ACCUM, line_run=1, pix_vld=1, win_left<=col<=win_left+win_width_m1, and win_top<=row<=win_top+win_height_m1.
REQ-026 SHALL set channel = {row[0]^bayer_phase[1], col[0]^bayer_phase[0]} when NCH=4, and 0 when NCH=1.
REQ-027 SHALL update counters in 3-stage read-increment-write, accepting one pixel per cycle.
REQ-028 SHALL forward in-flight results to same-address back-to-back pixels, so N identical pixels add exactly N.
REQ-029 SHALL hold a counter at 2^CNT_W-1 when cfg_sat=1, and wrap it to 0 when cfg_sat=0.
REQ-030 SHALL apply a frame_run fall mid-pipeline after in-flight updates complete; pending pixels SHALL NOT be lost.
REQ-031 SHALL return readout-bank data with rd_vld 2 cycles after rd_en, with no back-pressure, one read per cycle.
REQ-032 SHALL return the old bank to a request issued in the swap cycle.

Reset
REQ-033 SHALL set on rst_n=0 at posedge: state=IDLE, bank select=0, hist_ready=0, clr_late=0, rd_vld=0, rd_data=0, pipeline valids=0, counters=0.
REQ-034 SHALL leave memory contents undefined after reset; they are valid only after CLEAR.
REQ-035 SHALL abandon the frame on reset mid-ACCUM or mid-CLEAR; the next frame_run rise SHALL restart from CLEAR.

Structure
REQ-036 SHALL place state encoding, NCH legality check, and address-width functions in package histogram_pkg.
REQ-037 SHALL have one sub-module hist_bank_ram: dual-port RAM, 2*NCH*2^BIN_W x CNT_W, 1-cycle registered read.
REQ-038 SHALL keep the window and state machine in the top level.

Verification
REQ-039 SHALL cover: NCH=4, 8x4 window at (2,1), frame of pix=0x100, cfg_shift=4, bayer_phase=0 -> each channel's bin 16 = 8, all other bins 0.
REQ-040 SHALL cover: 1000 consecutive identical pixels in window -> bin = 1000 (forwarding check).
REQ-041 SHALL cover: CNT_W=4, cfg_sat=1, 20 hits -> 15; cfg_sat=0 -> 4.
REQ-042 SHALL cover: line_run asserted 10 cycles after frame_run with NCH=4, BIN_W=8 -> clr_late=1, early pixels uncounted.
REQ-043 SHALL cover: frames A then B -> after B starts, reads return A; hist_ready=1; rd_vld exactly 2 cycles after rd_en.
REQ-044 SHALL cover: rst_n=0 mid-ACCUM -> all outputs 0; next frame counts only post-reset pixels.
